countdown_timer_dp: RTL

//  Datapath for the lab6_2 down-count stopwatch; sits directly downstream of the stopwatch FSM.

---
 rtl/countdown_timer_dp.sv | 96 +++++++++
 1 files changed

// File: rtl/countdown_timer_dp.sv
// Down-count stopwatch datapath: BCD MM:SS preset and count, 1 Hz prescaler.
// Drives the four BCD display digits and reports count == 00:00 to the FSM.
module countdown_timer_dp #(
   parameter int          TICK_DIV = 100_000_000,
   parameter logic [7:0]  INIT_MIN = 8'h00,
   parameter logic [7:0]  INIT_SEC = 8'h30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       count_enable,
   input  logic       load_enable,
   input  logic       set_mode,
   input  logic       pb_min_inc,
   input  logic       pb_sec_inc,
   output logic       all_zero,
   output logic       tick,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;
   logic [7:0]    pre_min;
   logic [7:0]    pre_sec;
   logic [7:0]    cnt_min;
   logic [7:0]    cnt_sec;

   function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h59)
         r = 8'h00;
      else if (v[3:0] == 4'h9)
         r = {v[7:4] + 4'd1, 4'h0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // 00 wraps to 59; only reached for seconds, minutes are nonzero on borrow
   function automatic logic [7:0] bcd_dec59(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] != 4'h0)
         r = {v[7:4], v[3:0] - 4'd1};
      else if (v[7:4] != 4'h0)
         r = {v[7:4] - 4'd1, 4'h9};
      else
         r = 8'h59;
      return r;
   endfunction

   assign tick     = (presc == PMAX);
   assign all_zero = (cnt_min == 8'h00) && (cnt_sec == 8'h00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         presc <= '0;
      else if (load_enable || !count_enable || tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_min <= INIT_MIN;
         pre_sec <= INIT_SEC;
      end else if (set_mode) begin
         if (pb_sec_inc)
            pre_sec <= bcd_inc59(pre_sec);
         if (pb_min_inc)
            pre_min <= bcd_inc59(pre_min);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_min <= INIT_MIN;
         cnt_sec <= INIT_SEC;
      end else if (load_enable) begin
         cnt_min <= pre_min;
         cnt_sec <= pre_sec;
      end else if (tick && !all_zero) begin
         cnt_sec <= bcd_dec59(cnt_sec);
         if (cnt_sec == 8'h00)
            cnt_min <= bcd_dec59(cnt_min);
      end
   end

   assign {digit3, digit2} = set_mode ? pre_min : cnt_min;
   assign {digit1, digit0} = set_mode ? pre_sec : cnt_sec;

endmodule
